rgb_to_gray_seq: RTL and testbench
==================================

Name: rgb_to_gray_seq

Overview:
- Grayscale conversion stage that consumes the packed 24-bit pixel word delivered by the SPI control block, qualified by its one-cycle ready pulse.
- Produces an 8-bit luma value for the Sobel window logic.
- Computes gray = (R*COEF_R + G*COEF_G + B*COEF_B + rounding) >> 8 with a bit-serial shift-add datapath, so no hard multipliers are needed.
- Also supports a single-cycle bypass mode.

Parameters:
- COEF_R, 77, red weight (8-bit unsigned)
- COEF_G, 150, green weight (8-bit unsigned)
- COEF_B, 29, blue weight (8-bit unsigned)
- ROUND_EN, 1, when 1 the accumulator starts at 128 (round-to-nearest); when 0 it starts at 0 (truncate)
- Constraint: COEF_R+COEF_G+COEF_B must equal 256; elaboration fails otherwise.

Ports:
- clk_i  input  1  system clock
- nreset_i  input  1  asynchronous active-low reset
- px_rgb_i  input  24  packed pixel: [23:16]=R, [15:8]=G, [7:0]=B
- px_rdy_i  input  1  one-cycle strobe, px_rgb_i valid
- bypass_i  input  1  1 = output G channel directly, 0 = weighted luma; sampled with px_rdy_i
- clr_ovr_i  input  1  synchronous clear of overrun_o
- gray_o  output  8  registered result, held until the next result
- px_rdy_o  output  1  one-cycle strobe, gray_o updated this cycle
- busy_o  output  1  high while a conversion is in progress
- overrun_o  output  1  sticky; set when a pixel strobe is dropped

Behaviour:
- Reset (async, nreset_i low):
  - state=IDLE.
  - gray_o=0, px_rdy_o=0, busy_o=0, overrun_o=0.
  - Accumulator, operand registers and bit counter all 0.
  - Reset mid-conversion aborts the conversion; no px_rdy_o is produced for it.
- States: IDLE, CALC.
- IDLE, px_rdy_i=1, bypass_i=1 at edge E:
  - gray_o <= px_rgb_i[15:8]; px_rdy_o=1 in the cycle after E.
  - State stays IDLE; latency 1.
- IDLE, px_rdy_i=1, bypass_i=0 at edge E:
  - Capture R, G, B.
  - acc <= (ROUND_EN ? 128 : 0); k <= 0; state <= CALC.
- CALC, edges E+1..E+8, k=0..7 (k increments each edge):
  - acc <= acc + ((COEF_R[k]?R:0) + (COEF_G[k]?G:0) + (COEF_B[k]?B:0)) << k.
  - acc is 16 bits. The maximum reachable value is 65408, so overflow cannot occur.
- Final CALC edge (k=7, edge E+8):
  - gray_o <= bits [15:8] of the final sum; px_rdy_o=1 for one cycle; state <= IDLE.
  - Latency 8 cycles from the accepting edge to the px_rdy_o cycle. Throughput: one pixel per 9 cycles.
- busy_o = (state==CALC), combinational from the state register.
- px_rdy_o:
  - Never high for two consecutive cycles in weighted mode.
  - In bypass mode, back-to-back strobes give back-to-back px_rdy_o pulses.
- Overrun:
  - px_rdy_i=1 while in CALC (including edge E+8) drops the pixel and sets overrun_o.
  - The conversion in progress is unaffected.
- overrun_o stays set until clr_ovr_i=1.
  - If a drop and clr_ovr_i=1 occur on the same edge, set wins.
- gray_o changes only on result edges; it is stable at all other times.
- bypass_i and px_rgb_i are ignored except on accepting edges.

Test Plan:
- Reset, then px_rgb_i=0xFFFFFF strobe, bypass_i=0 -> px_rdy_o pulses exactly 8 cycles later, gray_o=255; px_rgb_i=0x000000 -> gray_o=0.
- Primaries, ROUND_EN=1:
  - 0xFF0000 -> 77
  - 0x00FF00 -> 149
  - 0x0000FF -> 29
  - 0x808080 -> 128
  - Same primaries with ROUND_EN=0: 76, 149, 28.
- Bypass: px_rgb_i=0x12AB34, bypass_i=1 -> gray_o=0xAB with px_rdy_o the next cycle, busy_o stays 0. Two consecutive strobes (0x12AB34, then 0x12CD34) -> two consecutive pulses, gray_o=0xAB then 0xCD.
- Overrun:
  - Strobe 0xFF0000, then a second strobe (0x00FF00) 3 cycles later -> single px_rdy_o with gray_o=77, overrun_o=1.
  - Strobe at edge E+8 -> also dropped.
  - clr_ovr_i -> overrun_o=0.
- Reset mid-CALC: assert nreset_i low 4 cycles after accept -> gray_o=0, busy_o=0, no px_rdy_o. After release, a new strobe of 0x808080 -> gray_o=128.
- Back-to-back weighted strobes spaced 9 cycles -> every pixel is accepted, overrun_o stays 0, results arrive in order.

Source files
------------

// File: rtl/rgb_to_gray_seq.sv
// Bit-serial RGB-to-luma converter: one coefficient bit per cycle, shift-add only.
// An optional bypass returns the G channel in a single cycle.
`timescale 1ns/1ps
module rgb_to_gray_seq #(
    parameter int unsigned COEF_R   = 77,
    parameter int unsigned COEF_G   = 150,
    parameter int unsigned COEF_B   = 29,
    parameter bit          ROUND_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        nreset_i,
    input  logic [23:0] px_rgb_i,
    input  logic        px_rdy_i,
    input  logic        bypass_i,
    input  logic        clr_ovr_i,
    output logic [7:0]  gray_o,
    output logic        px_rdy_o,
    output logic        busy_o,
    output logic        overrun_o
);

    generate
        if (COEF_R + COEF_G + COEF_B != 256) begin : g_bad_coef
            $error("rgb_to_gray_seq: COEF_R+COEF_G+COEF_B must equal 256");
        end
    endgenerate

    localparam logic [7:0]  LP_CR   = COEF_R[7:0];
    localparam logic [7:0]  LP_CG   = COEF_G[7:0];
    localparam logic [7:0]  LP_CB   = COEF_B[7:0];
    localparam logic [15:0] LP_INIT = ROUND_EN ? 16'd128 : 16'd0;

    typedef enum logic {S_IDLE, S_CALC} state_t;

    state_t      r_state;
    logic [7:0]  r_r, r_g, r_b;
    logic [15:0] r_acc;
    logic [2:0]  r_k;
    logic [7:0]  r_gray;
    logic        r_rdy;
    logic        r_ovr;

    logic [9:0]  w_term;
    logic [15:0] w_shifted;
    logic [15:0] w_sum;

    // Partial product for coefficient bit k, weighted by 2^k.
    always_comb begin
        w_term    = (LP_CR[r_k] ? {2'b00, r_r} : 10'd0)
                  + (LP_CG[r_k] ? {2'b00, r_g} : 10'd0)
                  + (LP_CB[r_k] ? {2'b00, r_b} : 10'd0);
        w_shifted = {6'd0, w_term} << r_k;
        w_sum     = r_acc + w_shifted;
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_state <= S_IDLE;
            r_r     <= 8'd0;
            r_g     <= 8'd0;
            r_b     <= 8'd0;
            r_acc   <= 16'd0;
            r_k     <= 3'd0;
            r_gray  <= 8'd0;
            r_rdy   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (clr_ovr_i)
                r_ovr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (px_rdy_i) begin
                        if (bypass_i) begin
                            r_gray <= px_rgb_i[15:8];
                            r_rdy  <= 1'b1;
                        end else begin
                            r_r     <= px_rgb_i[23:16];
                            r_g     <= px_rgb_i[15:8];
                            r_b     <= px_rgb_i[7:0];
                            r_acc   <= LP_INIT;
                            r_k     <= 3'd0;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    // A drop overrides a clear on the same edge.
                    if (px_rdy_i)
                        r_ovr <= 1'b1;
                    r_acc <= w_sum;
                    r_k   <= r_k + 3'd1;
                    if (r_k == 3'd7) begin
                        r_gray  <= w_sum[15:8];
                        r_rdy   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gray_o    = r_gray;
    assign px_rdy_o  = r_rdy;
    assign busy_o    = (r_state == S_CALC);
    assign overrun_o = r_ovr;

endmodule

// File: tb/tb_rgb_to_gray_seq.sv
// Scoreboard bench for rgb_to_gray_seq: a rounding and a truncating instance share stimulus.
`timescale 1ns/1ps
module tb_rgb_to_gray_seq;

    logic        clk = 1'b0;
    logic        nreset_i;
    logic [23:0] px_rgb_i;
    logic        px_rdy_i;
    logic        bypass_i;
    logic        clr_ovr_i;

    logic [7:0]  gray_r, gray_t;
    logic        rdy_r, rdy_t, busy_r, busy_t, ovr_r, ovr_t;

    always #5 clk = ~clk;

    rgb_to_gray_seq #(.COEF_R(77), .COEF_G(150), .COEF_B(29), .ROUND_EN(1'b1)) u_dut (
        .clk_i(clk), .nreset_i(nreset_i), .px_rgb_i(px_rgb_i), .px_rdy_i(px_rdy_i),
        .bypass_i(bypass_i), .clr_ovr_i(clr_ovr_i), .gray_o(gray_r), .px_rdy_o(rdy_r),
        .busy_o(busy_r), .overrun_o(ovr_r));

    rgb_to_gray_seq #(.COEF_R(77), .COEF_G(150), .COEF_B(29), .ROUND_EN(1'b0)) u_trn (
        .clk_i(clk), .nreset_i(nreset_i), .px_rgb_i(px_rgb_i), .px_rdy_i(px_rdy_i),
        .bypass_i(bypass_i), .clr_ovr_i(clr_ovr_i), .gray_o(gray_t), .px_rdy_o(rdy_t),
        .busy_o(busy_t), .overrun_o(ovr_t));

    typedef struct {
        logic [7:0] g;
        int         cyc;
    } exp_t;

    exp_t q_r[$];
    exp_t q_t[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic [7:0] last_r = 8'd0;
    logic [7:0] last_t = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] luma(input logic [23:0] p, input bit rnd);
        int unsigned s;
        s = 32'd77 * p[23:16] + 32'd150 * p[15:8] + 32'd29 * p[7:0] + (rnd ? 32'd128 : 32'd0);
        s = s >> 8;
        return s[7:0];
    endfunction

    // Output monitors for the rounding instance and the truncating instance.
    always @(negedge clk) begin
        exp_t e;
        if (nreset_i && rdy_r) begin
            n_chk++;
            if (q_r.size() == 0) begin
                $display("FAIL rnd_unexpected_rdy: gray=%0d at cyc %0d, nothing expected", gray_r, cyc);
            end else begin
                e = q_r.pop_front();
                if (gray_r !== e.g || cyc !== e.cyc)
                    $display("FAIL rnd_result: gray=%0d cyc=%0d, expected gray=%0d cyc=%0d", gray_r, cyc, e.g, e.cyc);
                else
                    n_pass++;
            end
        end else if (nreset_i) begin
            n_chk++;
            if (gray_r !== last_r)
                $display("FAIL rnd_gray_stable: gray=%0d, expected held %0d", gray_r, last_r);
            else
                n_pass++;
        end
        last_r = gray_r;
    end

    always @(negedge clk) begin
        exp_t e;
        if (nreset_i && rdy_t) begin
            n_chk++;
            if (q_t.size() == 0) begin
                $display("FAIL trn_unexpected_rdy: gray=%0d at cyc %0d, nothing expected", gray_t, cyc);
            end else begin
                e = q_t.pop_front();
                if (gray_t !== e.g || cyc !== e.cyc)
                    $display("FAIL trn_result: gray=%0d cyc=%0d, expected gray=%0d cyc=%0d", gray_t, cyc, e.g, e.cyc);
                else
                    n_pass++;
            end
        end else if (nreset_i) begin
            n_chk++;
            if (gray_t !== last_t)
                $display("FAIL trn_gray_stable: gray=%0d, expected held %0d", gray_t, last_t);
            else
                n_pass++;
        end
        last_t = gray_t;
    end

    // Called at a negedge; the strobe is sampled on the following posedge.
    task automatic pulse(input logic [23:0] rgb, input logic byp, input bit accept);
        exp_t e;
        if (accept) begin
            e.cyc = cyc + 1 + (byp ? 0 : 8);
            e.g   = byp ? rgb[15:8] : luma(rgb, 1'b1);
            q_r.push_back(e);
            e.g   = byp ? rgb[15:8] : luma(rgb, 1'b0);
            q_t.push_back(e);
        end
        px_rgb_i = rgb;
        bypass_i = byp;
        px_rdy_i = 1'b1;
        @(negedge clk);
        px_rdy_i = 1'b0;
        px_rgb_i = 24'($urandom);
        bypass_i = 1'($urandom);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && (q_r.size() != 0 || q_t.size() != 0); i++)
            @(negedge clk);
        n_chk++;
        if (q_r.size() != 0 || q_t.size() != 0) begin
            $display("FAIL %s_timeout: %0d/%0d results outstanding, expected 0/0", name, q_r.size(), q_t.size());
            q_r.delete();
            q_t.delete();
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_reset();
        nreset_i  = 1'b0;
        px_rgb_i  = 24'd0;
        px_rdy_i  = 1'b0;
        bypass_i  = 1'b0;
        clr_ovr_i = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({gray_r, rdy_r, busy_r, ovr_r} !== 11'd0)
            $display("FAIL reset_rnd: gray=%0d rdy=%b busy=%b ovr=%b, expected all 0", gray_r, rdy_r, busy_r, ovr_r);
        else n_pass++;
        n_chk++;
        if ({gray_t, rdy_t, busy_t, ovr_t} !== 11'd0)
            $display("FAIL reset_trn: gray=%0d rdy=%b busy=%b ovr=%b, expected all 0", gray_t, rdy_t, busy_t, ovr_t);
        else n_pass++;
        nreset_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_extremes();
        pulse(24'hFFFFFF, 1'b0, 1'b1);
        n_chk++;
        if (busy_r !== 1'b1) $display("FAIL busy_in_calc: busy=%b, expected 1", busy_r);
        else n_pass++;
        drain("white");
        n_chk++;
        if (gray_r !== 8'd255 || busy_r !== 1'b0)
            $display("FAIL white: gray=%0d busy=%b, expected 255 busy=0", gray_r, busy_r);
        else n_pass++;
        pulse(24'h000000, 1'b0, 1'b1);
        drain("black");
        n_chk++;
        if (gray_r !== 8'd0) $display("FAIL black: gray=%0d, expected 0", gray_r);
        else n_pass++;
    endtask

    task automatic test_primaries();
        logic [23:0] px   [4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h808080};
        logic [7:0]  exp_r[4] = '{8'd77, 8'd149, 8'd29, 8'd128};
        logic [7:0]  exp_t[4] = '{8'd76, 8'd149, 8'd28, 8'd128};
        for (int i = 0; i < 4; i++) begin
            pulse(px[i], 1'b0, 1'b1);
            drain("primary");
            n_chk++;
            if (gray_r !== exp_r[i] || gray_t !== exp_t[i])
                $display("FAIL primary_%06h: rnd=%0d trn=%0d, expected %0d/%0d", px[i], gray_r, gray_t, exp_r[i], exp_t[i]);
            else n_pass++;
        end
    endtask

    task automatic test_bypass();
        pulse(24'h12AB34, 1'b1, 1'b1);
        n_chk++;
        if (rdy_r !== 1'b1 || busy_r !== 1'b0 || gray_r !== 8'hAB)
            $display("FAIL bypass_single: rdy=%b busy=%b gray=%h, expected 1/0/ab", rdy_r, busy_r, gray_r);
        else n_pass++;
        drain("bypass1");
        pulse(24'h12AB34, 1'b1, 1'b1);
        pulse(24'h12CD34, 1'b1, 1'b1);
        n_chk++;
        if (rdy_r !== 1'b1 || busy_r !== 1'b0)
            $display("FAIL bypass_b2b: rdy=%b busy=%b, expected 1/0", rdy_r, busy_r);
        else n_pass++;
        drain("bypass2");
    endtask

    task automatic test_overrun();
        pulse(24'hFF0000, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        pulse(24'h00FF00, 1'b0, 1'b0);
        drain("ovr_mid");
        n_chk++;
        if (ovr_r !== 1'b1 || ovr_t !== 1'b1 || gray_r !== 8'd77)
            $display("FAIL overrun_mid: ovr=%b/%b gray=%0d, expected 1/1 77", ovr_r, ovr_t, gray_r);
        else n_pass++;
        clr_ovr_i = 1'b1;
        @(negedge clk);
        clr_ovr_i = 1'b0;
        n_chk++;
        if (ovr_r !== 1'b0 || ovr_t !== 1'b0)
            $display("FAIL overrun_clear: ovr=%b/%b, expected 0/0", ovr_r, ovr_t);
        else n_pass++;
        pulse(24'hFFFFFF, 1'b0, 1'b1);
        repeat (7) @(negedge clk);
        pulse(24'h000000, 1'b0, 1'b0);
        n_chk++;
        if (ovr_r !== 1'b1) $display("FAIL overrun_last_edge: ovr=%b, expected 1", ovr_r);
        else n_pass++;
        drain("ovr_last");
        clr_ovr_i = 1'b1;
        @(negedge clk);
        pulse(24'h808080, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        pulse(24'h00FF00, 1'b0, 1'b0);
        clr_ovr_i = 1'b0;
        n_chk++;
        if (ovr_r !== 1'b1) $display("FAIL overrun_set_wins: ovr=%b, expected 1", ovr_r);
        else n_pass++;
        drain("ovr_wins");
        clr_ovr_i = 1'b1;
        @(negedge clk);
        clr_ovr_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        pulse(24'hFFFFFF, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        nreset_i = 1'b0;
        q_r.delete();
        q_t.delete();
        @(negedge clk);
        n_chk++;
        if (gray_r !== 8'd0 || busy_r !== 1'b0 || rdy_r !== 1'b0)
            $display("FAIL reset_mid: gray=%0d busy=%b rdy=%b, expected 0/0/0", gray_r, busy_r, rdy_r);
        else n_pass++;
        repeat (2) @(negedge clk);
        nreset_i = 1'b1;
        repeat (12) @(negedge clk);
        pulse(24'h808080, 1'b0, 1'b1);
        drain("after_reset");
        n_chk++;
        if (gray_r !== 8'd128) $display("FAIL after_reset: gray=%0d, expected 128", gray_r);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            pulse(24'($urandom), 1'b0, 1'b1);
            repeat (8) @(negedge clk);
        end
        drain("b2b");
        n_chk++;
        if (ovr_r !== 1'b0 || ovr_t !== 1'b0)
            $display("FAIL b2b_overrun: ovr=%b/%b, expected 0/0", ovr_r, ovr_t);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_extremes();
        test_primaries();
        test_bypass();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
